frac_to_bcd: RTL and testbench
==============================

Name: frac_to_bcd

Overview:
- Sequential binary-fraction to decimal converter. It sits directly upstream of the decimal rounding stage.
- It takes an unsigned fixed-point value (1 integer bit, FRAC_W fraction bits) and produces the integer bit plus six BCD fraction digits, one digit per clock, by repeated multiply-by-10.
- Digits 1..5 are the value to display. Digit 6 is the rounding digit consumed by the rounding stage.
- It is used on the display/output path for fractional results (division, averages).

Parameters:
- FRAC_W, 16, number of fraction bits in din. The integer bit is din[FRAC_W].
- NUM_DIG, 6, number of fraction digits generated. Fixed at 6 to match the rounding stage; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Sampled only in IDLE.
- din  in  FRAC_W+1  value to convert. Bit FRAC_W is the integer part; bits FRAC_W-1:0 are the fraction.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse: result registers updated.
- int_o  out  1  integer bit of the last completed conversion.
- dig1..dig5  out  4 each  BCD fraction digits 1..5. dig1 is the tenths digit.
- dig6  out  4  BCD fraction digit 6, the rounding digit.

Behaviour:
- Reset: synchronous and active-high, so it acts only on a clk edge with rst=1. Reset state: IDLE, busy=0, valid=0, int_o=0, dig1..dig6=0, internal acc=0, cnt=0. Reset overrides start and any in-flight conversion. A partial conversion is discarded and the outputs are NOT updated with partial digits.
- States:
  - IDLE: busy=0. On an edge with start=1:
    - acc <= din[FRAC_W-1:0]
    - int_w <= din[FRAC_W]
    - cnt <= 0
    - go to CONV.
  - CONV: busy=1. Each edge computes p = acc*10 with width FRAC_W+4, implemented as (acc<<3)+(acc<<1).
    - Digit = p[FRAC_W+3:FRAC_W].
    - acc <= p[FRAC_W-1:0].
    - The digit is written to working digit slot cnt+1.
    - cnt <= cnt+1.
  - On the edge where cnt==NUM_DIG-1 (the 6th digit):
    - Copy int_w and all six working digits, including the digit produced that same edge, into int_o/dig1..dig6.
    - valid <= 1.
    - Return to IDLE.
- Latency: start is sampled at edge k. busy is high after edges k..k+5 and low after edge k+6. valid is high for exactly the cycle following edge k+6. Start-to-valid is 6 clocks.
- valid is a single-cycle pulse; it falls on the next edge unconditionally.
- Output registers hold their value between conversions. They change only on the completion edge or on reset.
- start while busy is ignored; no queuing. start is accepted in the cycle that valid is high, because the state is IDLE.
- din is sampled only on the accepting edge. Later changes to din do not affect the conversion in flight.
- Digit range: acc < 2^FRAC_W guarantees every digit is in 0..9. No digit correction is needed. Non-BCD codes must never appear on the outputs.
- Conversion truncates; it does not round. Rounding is the downstream stage's job.
- din with the integer bit set and fraction 0 gives int_o=1, all digits 0.
- cnt is 3 bits and never exceeds 5. There is no wrap-around.

Decomposition:
- Shared package holds:
  - the NUM_DIG=6 and BCD_W=4 constants
  - the state encoding IDLE/CONV
  - a digit-vector typedef (NUM_DIG x 4 bits), shared with the rounding stage.
- One natural sub-module: frac_mul10_step. It is combinational: acc in (FRAC_W), next acc out (FRAC_W), digit out (4). This isolates the arithmetic for unit testing.
- The FSM, counter, working registers and output registers stay in frac_to_bcd.

Test Plan:
- Fraction cases (FRAC_W=16), each with start=1 for one cycle:

| din | int_o | dig1..dig6 |
|---|---|---|
| 0x08000 (0.5) | 0 | 5,0,0,0,0,0 |
| 0x02000 (0.125) | 0 | 1,2,5,0,0,0 |

  For both, valid is high exactly 6 clocks after the start edge and busy is high for 6 cycles.
- Boundary cases:
  - din=0x0FFFF → int_o=0, digits 9,9,9,9,8,4.
  - din=0x00001 → digits 0,0,0,0,1,5 (dig6=5 drives round-up downstream).
  - din=0x10000 → int_o=1, all digits 0.
- Busy ignore: start with din=0x08000, then pulse start with din=0x0FFFF during CONV cycle 3 → exactly one valid, result 0/5,0,0,0,0,0. Outputs are unchanged after it until a new start.
- Back-to-back: assert start in the valid cycle with din=0x02000 → new conversion accepted; second valid 6 clocks later with 1,2,5,0,0,0. The first result is held until then.
- Reset mid-op: start with 0x0FFFF, assert rst at CONV cycle 4 → next cycle busy=0, valid=0, all outputs 0, and no valid pulse follows. A fresh start afterwards converts correctly.

Source files
------------

// File: rtl/frac_to_bcd_pkg.sv
// Shared constants and types for the fraction-to-BCD converter and the
// downstream rounding stage.
package frac_to_bcd_pkg;

   localparam int NUM_DIG = 6;
   localparam int BCD_W   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   // Index 0 holds digit 1 (tenths); index NUM_DIG-1 holds the rounding digit.
   typedef logic [NUM_DIG-1:0][BCD_W-1:0] dig_vec_t;

endpackage

// File: rtl/frac_mul10_step.sv
// One multiply-by-10 step: the carry-out above the binary point is the next
// decimal digit, the remaining bits are the new fraction.
module frac_mul10_step
   import frac_to_bcd_pkg::*;
#(
   parameter int FRAC_W = 16
) (
   input  logic [FRAC_W-1:0] acc,
   output logic [FRAC_W-1:0] acc_nxt,
   output logic [BCD_W-1:0]  digit
);

   logic [FRAC_W+3:0] acc_ext;
   logic [FRAC_W+3:0] p;

   // acc < 2^FRAC_W keeps p below 10*2^FRAC_W, so the digit is always 0..9.
   assign acc_ext = {4'b0000, acc};
   assign p       = (acc_ext << 3) + (acc_ext << 1);
   assign digit   = p[FRAC_W+3:FRAC_W];
   assign acc_nxt = p[FRAC_W-1:0];

endmodule

// File: rtl/frac_to_bcd.sv
// Sequential binary-fraction to BCD converter: one fraction digit per clock,
// six digits per conversion, results held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// CONV  | producing one digit per clock into working slot cnt+1
module frac_to_bcd
   import frac_to_bcd_pkg::*;
#(
   parameter int FRAC_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [FRAC_W:0]   din,
   output logic              busy,
   output logic              valid,
   output logic              int_o,
   output logic [BCD_W-1:0]  dig1,
   output logic [BCD_W-1:0]  dig2,
   output logic [BCD_W-1:0]  dig3,
   output logic [BCD_W-1:0]  dig4,
   output logic [BCD_W-1:0]  dig5,
   output logic [BCD_W-1:0]  dig6
);

   state_t            state_q;
   state_t            state_d;
   logic              accept;
   logic              done;

   logic [FRAC_W-1:0] acc_q;
   logic [FRAC_W-1:0] acc_nxt;
   logic [BCD_W-1:0]  digit;
   logic              int_w_q;
   logic [2:0]        cnt_q;
   dig_vec_t          work_q;
   dig_vec_t          work_d;

   dig_vec_t          out_q;
   logic              int_q;
   logic              valid_q;

   frac_mul10_step #(
      .FRAC_W (FRAC_W)
   ) u_step (
      .acc     (acc_q),
      .acc_nxt (acc_nxt),
      .digit   (digit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = CONV;
            end
         end
         CONV: begin
            if (cnt_q == 3'(NUM_DIG - 1)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The completion edge must publish the digit produced on that same edge.
   always_comb begin
      work_d        = work_q;
      work_d[cnt_q] = digit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         int_w_q <= 1'b0;
         cnt_q   <= '0;
         work_q  <= '0;
         out_q   <= '0;
         int_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= done;
         if (accept) begin
            acc_q   <= din[FRAC_W-1:0];
            int_w_q <= din[FRAC_W];
            cnt_q   <= '0;
         end else if (state_q == CONV) begin
            acc_q  <= acc_nxt;
            work_q <= work_d;
            cnt_q  <= done ? 3'd0 : cnt_q + 3'd1;
         end
         if (done) begin
            out_q <= work_d;
            int_q <= int_w_q;
         end
      end
   end

   assign busy  = (state_q == CONV);
   assign valid = valid_q;
   assign int_o = int_q;
   assign dig1  = out_q[0];
   assign dig2  = out_q[1];
   assign dig3  = out_q[2];
   assign dig4  = out_q[3];
   assign dig5  = out_q[4];
   assign dig6  = out_q[5];

endmodule

// File: tb/tb_frac_to_bcd.sv
// Scoreboard bench for frac_to_bcd: stimulus pushes decimal expectations
// computed by integer arithmetic, a negedge monitor checks every valid pulse.
module tb_frac_to_bcd;

   localparam int  FRAC_W = 16;
   localparam time PERIOD = 10;

   logic              clk;
   logic              rst;
   logic              start;
   logic [FRAC_W:0]   din;
   logic              busy;
   logic              valid;
   logic              int_o;
   logic [3:0]        dig1, dig2, dig3, dig4, dig5, dig6;

   typedef struct {
      logic [24:0] r;
      time         t;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   frac_to_bcd #(.FRAC_W(FRAC_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .busy  (busy),
      .valid (valid),
      .int_o (int_o),
      .dig1  (dig1),
      .dig2  (dig2),
      .dig3  (dig3),
      .dig4  (dig4),
      .dig5  (dig5),
      .dig6  (dig6)
   );

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   // Truncated decimal expansion: floor(frac * 10^6 / 2^16) read as 6 digits.
   function automatic logic [24:0] model(input logic [FRAC_W:0] d);
      longint      v;
      logic [23:0] r;
      v = longint'(d[FRAC_W-1:0]) * 64'd1000000 / (64'd1 << FRAC_W);
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return {d[FRAC_W], r};
   endfunction

   function automatic logic [24:0] outs();
      return {int_o, dig1, dig2, dig3, dig4, dig5, dig6};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got valid=1 expected no pending result at %0t", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", 64'(outs()), 64'(e.r));
            chk("valid_time", 64'($time), 64'(e.t));
         end
      end
   end

   // Caller is positioned just after a negedge. Issues start, pushes the
   // expectation, then follows busy; optionally pokes start while busy and
   // checks that held outputs stay put. Returns at the negedge where busy fell.
   task automatic run_conv(input logic [FRAC_W:0] d, input int ign,
                           input logic chk_hold, input logic [24:0] hold);
      exp_t e;
      int   nb;
      din   = d;
      start = 1'b1;
      @(posedge clk);
      e.r = model(d);
      e.t = $time + 6*PERIOD + PERIOD/2;
      q.push_back(e);
      nb = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         din   = 17'($urandom);
         if (busy !== 1'b1) break;
         nb++;
         if (chk_hold) chk("held_during_conv", 64'(outs()), 64'(hold));
         if (c + 1 == ign) start = 1'b1;
      end
      chk("busy_cycles", 64'(nb), 64'd6);
   endtask

   initial begin
      logic [FRAC_W:0] d;
      logic [24:0]     prev;
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_valid", 64'(valid), 64'd0);
      chk("reset_outputs", 64'(outs()), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed fraction and boundary cases.
      run_conv(17'h08000, 0, 1'b0, '0);
      run_conv(17'h02000, 0, 1'b0, '0);
      run_conv(17'h0FFFF, 0, 1'b0, '0);
      chk("max_frac_digits", 64'(outs()), 64'(25'h0999984));
      run_conv(17'h00001, 0, 1'b0, '0);
      chk("lsb_digits", 64'(outs()), 64'(25'h0000015));
      run_conv(17'h10000, 0, 1'b0, '0);
      chk("int_only", 64'(outs()), 64'(25'h1000000));
      run_conv(17'h00000, 0, 1'b0, '0);

      // start while busy is ignored; result then holds.
      repeat (2) @(negedge clk);
      run_conv(17'h08000, 3, 1'b0, '0);
      repeat (8) @(negedge clk);
      chk("hold_after_ignore", 64'(outs()), 64'(25'h0500000));

      // Back-to-back: accept in the valid cycle, first result held meanwhile.
      run_conv(17'h0FFFF, 0, 1'b0, '0);
      chk("valid_cycle", 64'(valid), 64'd1);
      run_conv(17'h02000, 0, 1'b1, model(17'h0FFFF));
      chk("b2b_second", 64'(outs()), 64'(25'h0125000));

      // Reset in CONV cycle 4 discards everything.
      @(negedge clk);
      din   = 17'h0FFFF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_valid", 64'(valid), 64'd0);
      chk("midrst_outputs", 64'(outs()), 64'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      run_conv(17'h02000, 0, 1'b0, '0);

      // Randomized values, gaps and ignored start pokes.
      for (int n = 0; n < 60; n++) begin
         d    = 17'($urandom_range(0, 17'h1FFFF));
         prev = outs();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_conv(d, int'($urandom_range(0, 5)), 1'b1, prev);
      end

      repeat (10) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
